// File: rtl/ncpu32k_psr_stack.sv
// Processor status register with a DEPTH-entry hardware stack of exception context (EPSR/EPC/ELSA).
// Registered state updates in one cycle; psr/psr_nold/epsr/epc/elsa are same-cycle bypassed views.
module ncpu32k_psr_stack #(
  parameter int DW         = 32,
  parameter int DEPTH      = 4,
  parameter int LVL_W      = 3,
  parameter int PSR_RM_RST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exp_ent,
  input  logic [DW-1:0]    exp_epc,
  input  logic [DW-1:0]    exp_elsa,
  input  logic             exp_ret,
  input  logic             psr_we,
  input  logic [9:0]       psr_nxt,
  input  logic             epsr_we,
  input  logic [9:0]       epsr_nxt,
  input  logic             epc_we,
  input  logic [DW-1:0]    epc_nxt,
  input  logic             elsa_we,
  input  logic [DW-1:0]    elsa_nxt,
  output logic [9:0]       psr,
  output logic [9:0]       psr_nold,
  output logic [9:0]       epsr,
  output logic [DW-1:0]    epc,
  output logic [DW-1:0]    elsa,
  output logic [LVL_W-1:0] lvl,
  output logic             stk_full,
  output logic             stk_ovf,
  output logic             stk_udf,
  input  logic             err_clr
);

  localparam int         IDX_W    = $clog2(DEPTH);
  // Implemented bits: CC[0], RM[4], IRE[5], IMME[6], DMME[7]
  localparam logic [9:0] PSR_MASK = 10'h0F1;
  localparam logic [9:0] PSR_RST  = (PSR_RM_RST != 0) ? 10'h010 : 10'h000;

  logic [9:0]       psr_q, psr_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [9:0]       epsr_q [DEPTH];
  logic [9:0]       epsr_d [DEPTH];
  logic [DW-1:0]    epc_q  [DEPTH];
  logic [DW-1:0]    epc_d  [DEPTH];
  logic [DW-1:0]    elsa_q [DEPTH];
  logic [DW-1:0]    elsa_d [DEPTH];

  logic             full, empty, top_we;
  logic [IDX_W-1:0] top_idx, push_idx;
  logic [9:0]       psr_nold_w, epsr_byp;
  logic [DW-1:0]    epc_byp, elsa_byp;

  always_comb begin
    full       = (lvl_q == LVL_W'(DEPTH));
    empty      = (lvl_q == '0);
    top_idx    = empty ? '0 : IDX_W'(lvl_q - LVL_W'(1));
    push_idx   = full ? IDX_W'(DEPTH - 1) : IDX_W'(lvl_q);
    top_we     = !empty && !exp_ent;
    psr_nold_w = psr_we ? (psr_nxt & PSR_MASK) : psr_q;
    epsr_byp   = (epsr_we && top_we) ? (epsr_nxt & PSR_MASK) : epsr_q[top_idx];
    epc_byp    = (epc_we  && top_we) ? epc_nxt  : epc_q[top_idx];
    elsa_byp   = (elsa_we && top_we) ? elsa_nxt : elsa_q[top_idx];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      epsr_d[i] = epsr_q[i];
      epc_d[i]  = epc_q[i];
      elsa_d[i] = elsa_q[i];
    end
    psr_d = psr_nold_w;
    lvl_d = lvl_q;
    ovf_d = ovf_q && !err_clr;
    udf_d = udf_q && !err_clr;

    if (exp_ent) begin
      // A full stack overwrites its top slot so the newest context stays returnable.
      epsr_d[push_idx] = psr_nold_w;
      epc_d[push_idx]  = exp_epc;
      elsa_d[push_idx] = exp_elsa;
      psr_d            = (psr_nold_w & 10'h001) | 10'h010;
      if (full) ovf_d = 1'b1;
      else      lvl_d = lvl_q + LVL_W'(1);
    end else begin
      if (top_we) begin
        epsr_d[top_idx] = epsr_byp;
        epc_d[top_idx]  = epc_byp;
        elsa_d[top_idx] = elsa_byp;
      end
      if (exp_ret) begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          psr_d = epsr_byp;
          lvl_d = lvl_q - LVL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psr_q <= PSR_RST;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        epsr_q[i] <= '0;
        epc_q[i]  <= '0;
        elsa_q[i] <= '0;
      end
    end else begin
      psr_q <= psr_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      for (int i = 0; i < DEPTH; i++) begin
        epsr_q[i] <= epsr_d[i];
        epc_q[i]  <= epc_d[i];
        elsa_q[i] <= elsa_d[i];
      end
    end
  end

  assign psr      = psr_d;
  assign psr_nold = psr_nold_w;
  assign epsr     = epsr_byp;
  assign epc      = epc_byp;
  assign elsa     = elsa_byp;
  assign lvl      = lvl_q;
  assign stk_full = full;
  assign stk_ovf  = ovf_q;
  assign stk_udf  = udf_q;

endmodule
